// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: binary value -> BCD (iterative shift-add-3) -> multiplexed
// active-low 7-segment scan with leading-zero blanking, overflow and error modes.
// Ports: clk, reset (async, active-high), value/load (start conversion),
//   show_error, blank_lz, blink (levels), busy, seg {g..a}, an (active-low).
// Optional macro SEG7_BLINK_EN adds a free-running blink counter gating an.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS    = 4,
  parameter int VALUE_W       = 14,
  parameter int REFRESH_DIV_W = 16,
  parameter int BLINK_DIV_W   = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic                  show_error,
  input  logic                  blank_lz,
  input  logic                  blink,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  // VALUE_W*3/10+1 never undercounts decimal digits for widths up to 27.
  localparam int DEC_D = VALUE_W * 3 / 10 + 1;
  localparam int BCD_D = (DEC_D > NUM_DIGITS) ? DEC_D : NUM_DIGITS;
  localparam int BCD_W = 4 * BCD_D;
  localparam int BUF_W = 4 * NUM_DIGITS;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(VALUE_W);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  function automatic logic [6:0] glyph7(input logic [3:0] d);
    case (d)
      4'd0:    glyph7 = 7'b1000000;
      4'd1:    glyph7 = 7'b1111001;
      4'd2:    glyph7 = 7'b0100100;
      4'd3:    glyph7 = 7'b0110000;
      4'd4:    glyph7 = 7'b0011001;
      4'd5:    glyph7 = 7'b0010010;
      4'd6:    glyph7 = 7'b0000010;
      4'd7:    glyph7 = 7'b1111000;
      4'd8:    glyph7 = 7'b0000000;
      4'd9:    glyph7 = 7'b0010000;
      default: glyph7 = SEG_BLANK;
    endcase
  endfunction

  logic                     busy_q, busy_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [VALUE_W-1:0]       sh_q, sh_d;
  logic [BCD_W-1:0]         bcd_q, bcd_d;
  logic [BUF_W-1:0]         buf_q, buf_d;
  logic                     ovf_q, ovf_d;
  logic [REFRESH_DIV_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [6:0]               seg_q, seg_d;
  logic [NUM_DIGITS-1:0]    an_q, an_d;

  logic [BCD_W-1:0] bcd_adj, bcd_nxt;
  logic             ovf_nxt;
  logic [3:0]       dig;
  logic             lz;

  // One double-dabble step: adjust digits >= 5, then shift in the next bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_D; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_nxt = {bcd_adj[BCD_W-2:0], sh_q[VALUE_W-1]};
    ovf_nxt = 1'b0;
    for (int i = NUM_DIGITS; i < BCD_D; i++) begin
      if (bcd_nxt[4*i +: 4] != 4'd0) ovf_nxt = 1'b1;
    end
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    buf_d  = buf_q;
    ovf_d  = ovf_q;
    if (!busy_q) begin
      if (load) begin
        busy_d = 1'b1;
        sh_d   = value;
        bcd_d  = '0;
        cnt_d  = CNT_W'(VALUE_W - 1);
      end
    end else begin
      sh_d  = {sh_q[VALUE_W-2:0], 1'b0};
      bcd_d = bcd_nxt;
      cnt_d = cnt_q - 1'b1;
      // Last bit: publish the full result in one edge.
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        buf_d  = bcd_nxt[BUF_W-1:0];
        ovf_d  = ovf_nxt;
      end
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == '1) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Zero digits at or above the current index -> leading zero.
  always_comb begin
    dig = buf_q[4*int'(idx_q) +: 4];
    lz  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx_q) && buf_q[4*i +: 4] != 4'd0) lz = 1'b0;
    end
  end

`ifdef SEG7_BLINK_EN
  logic [BLINK_DIV_W-1:0] blk_q, blk_d;

  always_comb blk_d = blk_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blk_q <= '0;
    else       blk_q <= blk_d;
  end
`else
  logic unused_blink;
  assign unused_blink = blink & (BLINK_DIV_W > 0);
`endif

  always_comb begin
    seg_d = glyph7(dig);
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    if (show_error) begin
      if (int'(idx_q) == NUM_DIGITS - 1) begin
        seg_d = SEG_E;
      end else if (int'(idx_q) == NUM_DIGITS - 2 ||
                   int'(idx_q) == NUM_DIGITS - 3) begin
        seg_d = SEG_R;
      end else begin
        seg_d = SEG_BLANK;
      end
    end else if (ovf_q) begin
      seg_d = SEG_DASH;
    end else if (blank_lz && idx_q != '0 && lz) begin
      seg_d = SEG_BLANK;
    end
`ifdef SEG7_BLINK_EN
    if (blink && blk_q[BLINK_DIV_W-1]) an_d = '1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      buf_q   <= '0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      buf_q   <= buf_d;
      ovf_q   <= ovf_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign busy = busy_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard bench for seg7_scan_ctrl (4 digits, 14 bits,
// prescaler width 2); directed scenarios followed by randomized loads/modes.
module tb_seg7_scan_ctrl;
  localparam int ND = 4;
  localparam int VW = 14;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [VW-1:0] value = '0;
  logic          load = 1'b0;
  logic          show_error = 1'b0;
  logic          blank_lz = 1'b0;
  logic          blink = 1'b0;
  logic          busy;
  logic [6:0]    seg;
  logic [ND-1:0] an;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS(ND),
    .VALUE_W(VW),
    .REFRESH_DIV_W(RW),
    .BLINK_DIV_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .load(load),
    .show_error(show_error),
    .blank_lz(blank_lz),
    .blink(blink),
    .busy(busy),
    .seg(seg),
    .an(an)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int model_val;
  bit model_ovf;

  logic [6:0] glyph_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [6:0] ref_seg(int val, bit ovf, int idx,
                                         bit se, bit bl);
    int p = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
    if (se) begin
      if (idx == ND - 1) return 7'h06;
      if (idx == ND - 2 || idx == ND - 3) return 7'h2F;
      return 7'h7F;
    end
    if (ovf) return 7'h3F;
    if (bl && idx != 0 && val < p) return 7'h7F;
    return glyph_tab[(val / p) % 10];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req,
               $time);
    end
  endtask

  // Monitor: tracks busy pulses, pops results, predicts every scan output.
  initial begin : monitor
    bit have_exp;
    logic [6:0] exp_seg;
    logic [ND-1:0] exp_an;
    int n, bcnt, idx, v;
    bit busy_prev;
    have_exp = 0; n = 0; bcnt = 0; busy_prev = 0;
    model_val = 0; model_ovf = 0;
    exp_seg = 7'h7F; exp_an = '1;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset seg", seg, 7'h7F);
        check("reset an", an, {ND{1'b1}});
        check("reset busy", busy, 1'b0);
        model_val = 0; model_ovf = 0;
        exp_q.delete();
        have_exp = 0; n = 0; bcnt = 0; busy_prev = 0;
      end else begin
        if (have_exp) begin
          check("seg", seg, exp_seg);
          check("an", an, exp_an);
        end else begin
          check("idle seg", seg, 7'h7F);
          check("idle an", an, {ND{1'b1}});
        end
        if (busy) begin
          bcnt++;
        end else if (busy_prev) begin
          check("busy width", bcnt, VW);
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected conversion: got result, required none");
          end else begin
            v = exp_q.pop_front();
            model_ovf = (v > 9999);
            model_val = v;
          end
          bcnt = 0;
        end
        busy_prev = busy;
        idx = (n / (1 << RW)) % ND;
        exp_seg = ref_seg(model_val, model_ovf, idx, show_error, blank_lz);
        exp_an = ~(ND'(1) << idx);
        have_exp = 1;
        n++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(int v, bit push);
    value = VW'(v);
    load = 1'b1;
    if (push) exp_q.push_back(v);
    tick();
    load = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL conversion timeout: got %0d pending, required 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int v;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();

    do_load(1234, 1); wait_done(); repeat (20) tick();
    do_load(10000, 1); wait_done(); repeat (20) tick();
    blank_lz = 1'b1;
    do_load(7, 1); wait_done(); repeat (20) tick();
    show_error = 1'b1; repeat (20) tick();
    show_error = 1'b0; repeat (20) tick();
    blank_lz = 1'b0;

    do_load(4321, 1); repeat (4) tick();
    do_load(99, 0); wait_done(); repeat (20) tick();

    do_load(5678, 1); repeat (6) tick();
    reset = 1'b1;
    #1;
    check("async reset busy", busy, 1'b0);
    check("async reset seg", seg, 7'h7F);
    check("async reset an", an, {ND{1'b1}});
    repeat (2) tick();
    reset = 1'b0;
    blank_lz = 1'b1;
    repeat (20) tick();
    blank_lz = 1'b0;

    repeat (40) begin
      case ($urandom % 4)
        0: v = int'($urandom_range(0, 99));
        1: v = int'($urandom_range(0, 9999));
        2: v = int'($urandom_range(10000, 16383));
        default: v = int'($urandom_range(0, 16383));
      endcase
      do_load(v, 1);
      for (int c = 0; c < 40; c++) begin
        if (c % 8 == 0) begin
          blank_lz = 1'($urandom % 2);
          show_error = ($urandom % 4 == 0);
          blink = 1'($urandom % 2);
        end
        load = 1'b0;
        if (c == 3 && $urandom % 3 == 0) begin
          value = VW'($urandom);
          load = 1'b1;
        end
        tick();
      end
      load = 1'b0;
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits, legal 2..8.
REQ-002 Parameter VALUE_W, default 14, binary input width, legal 4..27.
REQ-003 Parameter REFRESH_DIV_W, default 16, prescaler width; digit advances once per 2^REFRESH_DIV_W clocks.
REQ-004 Parameter BLINK_DIV_W, default 24, blink counter width (used only with SEG7_BLINK_EN).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 value  input  VALUE_W  unsigned binary number to display.
REQ-008 load  input  1  single-cycle request to latch value and start conversion.
REQ-009 show_error  input  1  level; displays error pattern while high.
REQ-010 blank_lz  input  1  level; enables leading-zero blanking.
REQ-011 blink  input  1  level; blinks whole display (SEG7_BLINK_EN only).
REQ-012 busy  output  1  high while binary-to-BCD conversion in progress.
REQ-013 seg  output  7  registered segment pattern {g,f,e,d,c,b,a}, active-low.
REQ-014 an  output  NUM_DIGITS  registered digit enables, active-low, at most one low.

Function
REQ-015 load sampled high while busy=0 SHALL latch value and assert busy on the next edge; load while busy=1 SHALL be ignored.
REQ-016 Conversion SHALL be iterative shift-add-3, one bit per clock; busy SHALL stay high exactly VALUE_W cycles.
REQ-017 The displayed digit buffer SHALL update atomically on the edge busy falls; no partial result ever displayed.
REQ-018 Latched value > 10^NUM_DIGITS-1 SHALL set overflow: every digit shows '-' (seg=0111111) until next completed conversion.
REQ-019 Prescaler SHALL free-run; on wrap to 0 the scan index SHALL advance, wrapping NUM_DIGITS-1 -> 0 (never reaching unused codes).
REQ-020 an SHALL drive low only bit [index]; seg/an SHALL reflect index/buffer/modes one clock after they change (one register stage).
REQ-021 Digit glyphs 0-9 SHALL use standard active-low codes (0=1000000, 1=1111001, ..., 9=0010000).
REQ-022 blank_lz=1 SHALL blank (seg=1111111, an still scanned) zero digits above the most significant nonzero digit; digit 0 always shown.
REQ-023 show_error=1 SHALL override all: top digit 'E' (0000110), next two 'r' (0101111), remaining digits blank; buffer and conversion unaffected.
REQ-024 Priority: show_error > overflow > blank_lz > normal digit.
REQ-025 load accepted on the same edge busy falls SHALL NOT occur; load is only accepted when busy is already 0.

Reset
REQ-026 reset SHALL asynchronously force seg=1111111, an=all ones, busy=0, scan index 0, prescaler 0, buffer all zero, overflow 0.
REQ-027 Reset mid-conversion SHALL abort it; the buffer stays zero until a new load completes.
REQ-028 After reset release, first displayed content SHALL be value 0 (digit 0 shows '0', others '0' or blank per blank_lz).

Configuration
REQ-029 Macro SEG7_BLINK_EN defined: BLINK_DIV_W-bit counter free-runs; while blink=1 and counter MSB=1, an SHALL be all ones; counter reset to 0.
REQ-030 SEG7_BLINK_EN undefined: no blink counter instantiated; blink port present but ignored; display never blanked by blink.

Verification (NUM_DIGITS=4, VALUE_W=14, REFRESH_DIV_W=2)
REQ-031 load with value=1234 -> busy high 14 cycles; then scan shows an=1110 seg '4', 1101 '3', 1011 '2', 0111 '1', index wraps back to 0.
REQ-032 value=10000 loaded -> all four digits show 0111111; then value=7 with blank_lz=1 -> only an=1110 shows '7', other digits seg=1111111.
REQ-033 show_error=1 during scan -> 0111 'E', 1011 'r', 1101 'r', 1110 blank; drop show_error -> prior number reappears unchanged.
REQ-034 load=1 asserted again 5 cycles into conversion with different value -> ignored; original result displayed; busy width still 14.
REQ-035 reset pulsed at conversion cycle 7 -> seg=1111111, an=1111, busy=0 immediately; after release display shows 0.
REQ-036 SEG7_BLINK_EN, BLINK_DIV_W=4, blink=1 -> an all ones for 8 of every 16 clocks; blink=0 -> normal scan continuously.
